// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
// Module      : popcount_pkg
// Description : Shared definitions for the 22-input popcount family.
//               - Default word length and count width.
//               - Unary-generator FSM state type.
//               - Saturate-to-N helper, also used by popcount checkers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package popcount_pkg;

  // Default number of popcount inputs and width of a count that covers them.
  localparam int POPCNT_N_BITS = 22;
  localparam int POPCNT_CNT_W  = 5;

  // Unary generator control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamp a requested count to the number of available bit positions.
  function automatic int unsigned sat_to_n(input int unsigned count,
                                           input int unsigned n);
    return (count > n) ? n : count;
  endfunction

endpackage : popcount_pkg
`default_nettype wire

// File: rtl/popcount22_unary_shreg.sv
`default_nettype none
// ============================================================================
// Module      : popcount22_unary_shreg
// Description : N_BITS-wide indexed-write register. Each accepted serial bit
//               is written at its bit index; a synchronous clear empties the
//               word before a new request is assembled.
// Ports       : clk     - clock
//               rst_n   - asynchronous active-low reset
//               clr     - clear whole word (priority over write)
//               wr_en   - write wr_bit at position wr_idx
//               wr_idx  - bit position to write
//               wr_bit  - value to write
//               word    - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module popcount22_unary_shreg
  import popcount_pkg::*;
#(
  parameter int N_BITS = POPCNT_N_BITS,
  localparam int IDX_W = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_bit,
  output logic [N_BITS-1:0] word
);

  logic [N_BITS-1:0] r_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
    end else if (clr) begin
      r_word <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < N_BITS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          r_word[i] <= wr_bit;
        end
      end
    end
  end

  assign word = r_word;

endmodule : popcount22_unary_shreg
`default_nettype wire

// File: rtl/popcount22_unary_gen.sv
`default_nettype none
// ============================================================================
// Module      : popcount22_unary_gen
// Description : Regenerates an N_BITS-wide unary (thermometer) word holding
//               exactly in_count ones (clamped to N_BITS). The word is sent
//               bit-serially, index 0 first, on a valid/ready stream and is
//               also presented in parallel on vec_data with a one-cycle
//               vec_valid pulse once the last bit has been transferred.
// Ports       : clk       - clock, rising edge
//               rst_n     - asynchronous active-low reset
//               in_valid  - count request valid
//               in_ready  - generator idle, request can be accepted
//               in_count  - requested number of ones
//               out_valid - serial bit valid
//               out_ready - downstream accepts serial bit
//               out_bit   - current unary bit
//               out_last  - current bit is index N_BITS-1
//               vec_valid - one-cycle pulse, vec_data complete
//               vec_data  - assembled unary word (held until next pulse)
//               sat_flag  - request exceeded N_BITS and was clamped
// Revision    : 1.0 - initial release
// ============================================================================
module popcount22_unary_gen
  import popcount_pkg::*;
#(
  parameter int N_BITS = POPCNT_N_BITS,
  parameter int CNT_W  = POPCNT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic              vec_valid,
  output logic [N_BITS-1:0] vec_data,
  output logic              sat_flag
);

  localparam int              IDX_W      = $clog2(N_BITS);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_BITS - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sat_next;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_bit;
  logic              r_out_last;
  logic              r_vec_valid;
  logic [N_BITS-1:0] r_vec_data;
  logic              r_sat_flag;

  logic              w_accept;
  logic              w_xfer;
  logic [CNT_W-1:0]  w_cnt_clamped;
  logic              w_cnt_sat;
  logic [IDX_W-1:0]  w_idx_inc;
  logic [N_BITS-1:0] w_shreg_word;
  logic [N_BITS-1:0] w_final_word;

  // In IDLE the ready flop is always set, so acceptance reduces to in_valid.
  assign w_accept      = (r_state == IDLE) && in_valid;
  assign w_xfer        = (r_state == EMIT) && out_ready;
  assign w_cnt_clamped = CNT_W'(sat_to_n(32'(in_count), unsigned'(N_BITS)));
  assign w_cnt_sat     = 32'(in_count) > unsigned'(N_BITS);
  assign w_idx_inc     = r_idx + IDX_W'(1);

  popcount22_unary_shreg #(
    .N_BITS (N_BITS)
  ) u_shreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_accept),
    .wr_en  (w_xfer),
    .wr_idx (r_idx),
    .wr_bit (r_out_bit),
    .word   (w_shreg_word)
  );

  // The last serial bit is written into the shift register on the same edge
  // that publishes vec_data, so merge it in here to have the full word ready
  // during the DONE cycle.
  always_comb begin
    w_final_word = w_shreg_word;
    for (int i = 0; i < N_BITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_final_word[i] = r_out_bit;
      end
    end
  end

  // Single control process; every stream output is a flop loaded with its
  // next-cycle value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_sat_next  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_last  <= 1'b0;
      r_vec_valid <= 1'b0;
      r_vec_data  <= '0;
      r_sat_flag  <= 1'b0;
    end else begin
      r_vec_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cnt       <= w_cnt_clamped;
            r_sat_next  <= w_cnt_sat;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_bit   <= (w_cnt_clamped != '0);
            r_out_last  <= (c_last_idx == '0);
            r_state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_bit   <= 1'b0;
              r_out_last  <= 1'b0;
              r_vec_valid <= 1'b1;
              r_vec_data  <= w_final_word;
              r_sat_flag  <= r_sat_next;
              r_state     <= DONE;
            end else begin
              // idx stays at N_BITS-1 after the final bit; it is only
              // advanced on a non-last transfer.
              r_idx      <= w_idx_inc;
              r_out_bit  <= (32'(w_idx_inc) < 32'(r_cnt));
              r_out_last <= (w_idx_inc == c_last_idx);
            end
          end
        end
        DONE: begin
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_last  = r_out_last;
  assign vec_valid = r_vec_valid;
  assign vec_data  = r_vec_data;
  assign sat_flag  = r_sat_flag;

endmodule : popcount22_unary_gen
`default_nettype wire

// File: tb/tb_popcount22_unary_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount22_unary_gen
// Description : Self-checking bench for popcount22_unary_gen. A transfer-
//               counting reference model predicts every output on every
//               cycle; directed scenarios pin the model with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount22_unary_gen;

  localparam int N = 22;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [4:0]    in_count = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_bit;
  logic          out_last;
  logic          vec_valid;
  logic [N-1:0]  vec_data;
  logic          sat_flag;

  int n_chk  = 0;
  int n_fail = 0;
  int ready_mode = 0;   // 0: out_ready always high, 1: random

  // Model state
  bit           m_busy = 1'b0;
  int           m_job = 0;
  int           m_k = 0;
  logic [N-1:0] m_last_vec = '0;
  logic         m_last_sat = 1'b0;
  int           m_cyc = 0;
  int           m_acc_cyc = 0;

  // Captured results for the directed pins
  logic [N-1:0] cap_vec[$];
  logic         cap_sat[$];
  int           cap_lat[$];
  int           acc_q[$];

  popcount22_unary_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .vec_valid (vec_valid),
    .vec_data  (vec_data),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int c);
    return (c > N) ? N : c;
  endfunction

  function automatic logic [N-1:0] unary(input int c);
    logic [31:0] m;
    m = (32'd1 << clamp(c)) - 32'd1;
    return m[N-1:0];
  endfunction

  // Downstream ready generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Reference model and per-cycle comparison
  initial begin
    forever begin
      @(negedge clk);
      m_cyc++;
      if (!rst_n) begin
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bit", 32'(out_bit), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_vec_valid", 32'(vec_valid), 32'd0);
        chk("rst_vec_data", 32'(vec_data), 32'd0);
        chk("rst_sat_flag", 32'(sat_flag), 32'd0);
        m_busy = 1'b0;
        m_k = 0;
        m_last_vec = '0;
        m_last_sat = 1'b0;
      end else begin
        chk("in_ready", 32'(in_ready), 32'(!m_busy));
        chk("out_valid", 32'(out_valid), 32'(m_busy && m_k < N));
        if (m_busy && m_k < N) begin
          chk("out_bit", 32'(out_bit), 32'(m_k < clamp(m_job)));
          chk("out_last", 32'(out_last), 32'(m_k == N - 1));
        end
        chk("vec_valid", 32'(vec_valid), 32'(m_busy && m_k == N));
        if (m_busy && m_k == N) begin
          m_last_vec = unary(m_job);
          m_last_sat = (m_job > N);
        end
        chk("vec_data", 32'(vec_data), 32'(m_last_vec));
        chk("sat_flag", 32'(sat_flag), 32'(m_last_sat));
        if (vec_valid) begin
          cap_vec.push_back(vec_data);
          cap_sat.push_back(sat_flag);
          cap_lat.push_back(m_cyc - m_acc_cyc);
        end
        // Predict the effect of the coming rising edge.
        if (!m_busy) begin
          if (in_valid) begin
            m_busy = 1'b1;
            m_job = int'(in_count);
            m_k = 0;
            m_acc_cyc = m_cyc;
            acc_q.push_back(m_cyc);
          end
        end else if (m_k < N) begin
          if (out_ready) m_k++;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic send(input int c, input bit keep);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_count = 5'(c);
    forever begin
      @(negedge clk);
      #1;
      if (in_ready) break;
      t++;
      if (t > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: count %0d not accepted within 200 cycles", c);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
    in_count = 5'($urandom);   // post-accept changes must be ignored
  endtask

  task automatic wait_vec(input int n_before);
    int t;
    t = 0;
    while (cap_vec.size() <= n_before) begin
      @(negedge clk);
      #1;
      t++;
      if (t > 600) begin
        n_chk++;
        n_fail++;
        $display("FAIL vec_timeout: no vec_valid within 600 cycles, got %0d results", cap_vec.size());
        break;
      end
    end
  endtask

  initial begin
    int n;
    int t;
    int c;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Count 7 with ready high
    ready_mode = 0;
    n = cap_vec.size();
    send(7, 1'b0);
    wait_vec(n);
    chk("t1_vec", 32'(cap_vec[n]), 32'h00007F);
    chk("t1_sat", 32'(cap_sat[n]), 32'd0);
    chk("t1_latency", 32'(cap_lat[n]), 32'd23);

    // Back-to-back 0 then 22 with in_valid held
    n = cap_vec.size();
    send(0, 1'b1);
    send(22, 1'b0);
    wait_vec(n + 1);
    chk("t2_vec0", 32'(cap_vec[n]), 32'h000000);
    chk("t2_vec22", 32'(cap_vec[n+1]), 32'h3FFFFF);
    chk("t2_sat22", 32'(cap_sat[n+1]), 32'd0);
    chk("t2_period", 32'(acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2]), 32'd24);

    // Saturation then a small count
    n = cap_vec.size();
    send(31, 1'b0);
    wait_vec(n);
    send(3, 1'b0);
    wait_vec(n + 1);
    chk("t3_vec31", 32'(cap_vec[n]), 32'h3FFFFF);
    chk("t3_sat31", 32'(cap_sat[n]), 32'd1);
    chk("t3_vec3", 32'(cap_vec[n+1]), 32'h000007);
    chk("t3_sat3", 32'(cap_sat[n+1]), 32'd0);

    // Count 12 with random back-pressure
    ready_mode = 1;
    n = cap_vec.size();
    send(12, 1'b0);
    wait_vec(n);
    chk("t4_vec", 32'(cap_vec[n]), 32'h000FFF);

    // Reset in the middle of a 15-count job
    n = cap_vec.size();
    send(15, 1'b0);
    t = 0;
    while (m_k < 10 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("t5_reached_idx10", 32'(m_k >= 10), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t5_no_vec_pulse", 32'(cap_vec.size()), 32'(n));
    send(5, 1'b0);
    wait_vec(n);
    chk("t5_vec5", 32'(cap_vec[n]), 32'h00001F);

    // Loopback through an exact popcount for every legal count
    for (int k = 0; k <= N; k++) begin
      n = cap_vec.size();
      send(k, 1'b0);
      wait_vec(n);
      chk("loop_popcount", 32'($countones(cap_vec[n])), 32'(k));
    end

    // Random counts across the full input range
    for (int r = 0; r < 12; r++) begin
      c = int'($urandom_range(0, 31));
      ready_mode = int'($urandom_range(0, 1));
      n = cap_vec.size();
      send(c, 1'b0);
      wait_vec(n);
      chk("rand_popcount", 32'($countones(cap_vec[n])), 32'(clamp(c)));
      chk("rand_sat", 32'(cap_sat[n]), 32'(c > N));
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_popcount22_unary_gen
`default_nettype wire

// File: doc/popcount22_unary_gen.md
Name: popcount22_unary_gen

Overview:
- Inverse of the 22-input popcount: takes a 5-bit count and regenerates a 22-bit unary (thermometer) word containing exactly that many ones.
- Emits the word bit-serially over a valid/ready stream and also as a parallel vector.
- Drives 22-input popcount cores in closed-loop characterisation: generated vector → popcount → compare against the original count.
- Also serves as the unary stream source for on-sensor ternary-neuron test harnesses.

Parameters:
- N_BITS, 22, length of the generated unary word (number of popcount inputs).
- CNT_W, 5, width of the count input; must satisfy 2**CNT_W > N_BITS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  count request valid.
- in_ready  output  1  block can accept a count.
- in_count  input  CNT_W  requested number of ones.
- out_valid  output  1  serial bit valid.
- out_ready  input  1  downstream accepts serial bit.
- out_bit  output  1  current unary bit, index 0 first.
- out_last  output  1  marks bit index N_BITS-1.
- vec_valid  output  1  one-cycle pulse: vec_data complete.
- vec_data  output  N_BITS  assembled unary word; bit i = (i < count).
- sat_flag  output  1  in_count exceeded N_BITS and was clamped; valid with vec_data.

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; out_bit=0; out_last=0.
  - vec_valid=0; vec_data=0; sat_flag=0; internal idx=0, cnt=0.
- FSM states: IDLE, EMIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: cnt ← min(in_count, N_BITS); sat_next ← (in_count > N_BITS); idx ← 0; clear the vec shift register; go to EMIT.
- EMIT:
  - in_ready=0; out_valid=1; out_bit=(idx < cnt); out_last=(idx == N_BITS-1).
  - On out_valid&out_ready: write vec_shift[idx] ← out_bit; idx ← idx+1.
  - If out_last was set on that transfer, go to DONE.
  - out_ready=0 holds out_bit, out_last and idx stable; standard stream rule, no bit is dropped or duplicated.
- DONE (exactly one cycle):
  - vec_valid=1; vec_data ← completed word; sat_flag ← sat_next; out_valid=0; in_ready=0; next state IDLE.
- vec_data and sat_flag hold their values until the next DONE; they are not cleared on a new accept.
- Latency: accept at edge t, first out_valid in cycle t+1. With out_ready tied high, vec_valid asserts N_BITS+1 cycles after accept. Throughput is one count per N_BITS+2 cycles.
- Boundary conditions:
  - in_count=0: all out_bit=0; vec_data=0; sat_flag=0.
  - in_count=N_BITS: all ones, sat_flag=0.
  - in_count in N_BITS+1..2**CNT_W-1: clamped to all ones, sat_flag=1.
- in_valid during EMIT/DONE is ignored (in_ready=0); the upstream must hold it, and no request is lost.
- idx never exceeds N_BITS-1; its width is $clog2(N_BITS).
- Reset asserted mid-EMIT: immediate abort to reset values; no vec_valid pulse; the partial word is discarded.
- in_count is sampled only at accept; changes afterwards have no effect.

Decomposition:
- Shared package popcount_pkg holds:
  - N_BITS/CNT_W defaults.
  - The state enum type (IDLE/EMIT/DONE).
  - A saturate-to-N_BITS function reused by popcount checkers.
- One sub-module, popcount22_unary_shreg: an indexed write register, N_BITS wide, with clear and a write-enable; the word is assembled there.
- FSM, counter and handshake stay in the top module.

Test Plan:
- Reset then in_count=7, out_ready=1:
  - out_bit=1 for indices 0..6, 0 for 7..21.
  - out_last on the 22nd bit.
  - vec_valid pulse with vec_data=22'h00007F, sat_flag=0, 23 cycles after accept.
- in_count=0, then in_count=22, back-to-back in_valid: vec_data=22'h000000 then 22'h3FFFFF; the second request is accepted only after DONE→IDLE.
- in_count=31: all 22 bits are 1, vec_data=22'h3FFFFF, sat_flag=1. A following in_count=3 gives vec_data=22'h000007 and sat_flag=0.
- in_count=12 with out_ready toggling in a pseudo-random pattern: exactly 22 transfers, first 12 are ones; bit and last are stable while stalled; vec_data=22'h000FFF.
- rst_n pulsed low at transfer index 10 of in_count=15: outputs return to reset values, no vec_valid, in_ready=1. A new in_count=5 then yields vec_data=22'h00001F.
- Loopback through a 22-input popcount core for all counts 0..22: the exact core returns equal counts; approximate cores are logged for error-metric comparison.
